// File: rtl/xy_route_alloc.sv
// Five-port XY mesh router allocator: Y-first route compute, per-output round-robin
// arbitration gated by downstream credits, registered outputs and a saturating drop counter.
module xy_route_alloc #(
  parameter int          DATA_W  = 8,
  parameter int          COORD_W = 4,
  parameter int          XCOORD  = 1,
  parameter int          YCOORD  = 1,
  parameter logic [4:0]  PORT_EN = 5'b11111,
  parameter int          CREDITS = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [5*DATA_W-1:0] in_data,
  input  logic [4:0]          in_valid,
  output logic [4:0]          in_ready,
  output logic [5*DATA_W-1:0] out_data,
  output logic [4:0]          out_valid,
  input  logic [4:0]          credit_in,
  output logic [15:0]         drop_cnt
);

  localparam int CW = $clog2(CREDITS + 1);

  localparam logic [2:0] P_N    = 3'd0;
  localparam logic [2:0] P_S    = 3'd1;
  localparam logic [2:0] P_E    = 3'd2;
  localparam logic [2:0] P_W    = 3'd3;
  localparam logic [2:0] P_L    = 3'd4;
  localparam logic [2:0] P_DROP = 3'd7;

  localparam logic [COORD_W-1:0] X_POS = COORD_W'(XCOORD);
  localparam logic [COORD_W-1:0] Y_POS = COORD_W'(YCOORD);
  localparam logic [CW-1:0]      C_MAX = CW'(CREDITS);

  // Codes 5..7 index zeros, so an unroutable flit reads as a disabled output.
  localparam logic [7:0] EN8 = {3'b000, PORT_EN};

  function automatic logic [2:0] route_fn(input logic [2:0] src,
                                          input logic [COORD_W-1:0] dx,
                                          input logic [COORD_W-1:0] dy);
    logic [2:0] x_dir;
    x_dir    = (dx > X_POS) ? P_E : ((dx < X_POS) ? P_W : P_L);
    route_fn = P_DROP;
    case (src)
      P_N: begin
        if (dy > Y_POS)       route_fn = P_S;
        else if (dy == Y_POS) route_fn = x_dir;
      end
      P_S: begin
        if (dy < Y_POS)       route_fn = P_N;
        else if (dy == Y_POS) route_fn = x_dir;
      end
      P_E: begin
        if (dy == Y_POS && dx < X_POS)       route_fn = P_W;
        else if (dy == Y_POS && dx == X_POS) route_fn = P_L;
      end
      P_W: begin
        if (dy == Y_POS && dx > X_POS)       route_fn = P_E;
        else if (dy == Y_POS && dx == X_POS) route_fn = P_L;
      end
      default: begin
        if (dy > Y_POS)       route_fn = P_S;
        else if (dy < Y_POS)  route_fn = P_N;
        else if (dx != X_POS) route_fn = x_dir;
      end
    endcase
  endfunction

  logic [4:0]        req   [5];
  logic [4:0]        grant [5];
  logic [2:0]        win   [5];
  logic [4:0]        drop_vec;
  logic [CW-1:0]     credit [5];
  logic [2:0]        ptr    [5];
  logic [DATA_W-1:0] sel_data [5];

  always_comb begin
    logic [2:0] tgt;
    for (int o = 0; o < 5; o++) req[o] = '0;
    drop_vec = '0;
    tgt      = P_DROP;
    for (int i = 0; i < 5; i++) begin
      if (in_valid[i]) begin
        tgt = route_fn(3'(i),
                       in_data[i*DATA_W+COORD_W +: COORD_W],
                       in_data[i*DATA_W +: COORD_W]);
        if (!PORT_EN[i] || !EN8[tgt]) drop_vec[i] = 1'b1;
        else                          req[tgt][i] = 1'b1;
      end
    end
  end

  // Each input requests at most one output, so per-output arbiters never double-grant an input.
  always_comb begin
    int         s;
    logic [2:0] idx;
    logic       found;
    s     = 0;
    idx   = '0;
    found = 1'b0;
    for (int o = 0; o < 5; o++) begin
      grant[o]    = '0;
      win[o]      = '0;
      sel_data[o] = '0;
      found       = 1'b0;
      for (int k = 0; k < 5; k++) begin
        s = int'(ptr[o]) + k;
        if (s >= 5) s = s - 5;
        idx = 3'(s);
        if (!found && req[o][idx] && credit[o] != '0) begin
          found         = 1'b1;
          grant[o][idx] = 1'b1;
          win[o]        = idx;
          sel_data[o]   = in_data[s*DATA_W +: DATA_W];
        end
      end
    end
  end

  always_comb begin
    in_ready = drop_vec;
    for (int o = 0; o < 5; o++) in_ready = in_ready | grant[o];
  end

  logic [2:0]  n_drop;
  logic [16:0] drop_sum;

  always_comb begin
    n_drop = '0;
    for (int i = 0; i < 5; i++) n_drop = n_drop + 3'(drop_vec[i]);
    drop_sum = {1'b0, drop_cnt} + 17'(n_drop);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= '0;
      out_data  <= '0;
      drop_cnt  <= '0;
      for (int o = 0; o < 5; o++) begin
        credit[o] <= C_MAX;
        ptr[o]    <= '0;
      end
    end else begin
      drop_cnt <= drop_sum[16] ? 16'hFFFF : drop_sum[15:0];
      for (int o = 0; o < 5; o++) begin
        out_valid[o] <= |grant[o];
        if (|grant[o]) begin
          out_data[o*DATA_W +: DATA_W] <= sel_data[o];
          ptr[o] <= (win[o] == 3'd4) ? 3'd0 : win[o] + 3'd1;
        end
        case ({|grant[o], credit_in[o]})
          2'b10:   credit[o] <= credit[o] - 1'b1;
          2'b01:   if (credit[o] != C_MAX) credit[o] <= credit[o] + 1'b1;
          default: credit[o] <= credit[o];
        endcase
      end
    end
  end

endmodule
